// File: rtl/search_pkg.sv
// Shared types for the search job sequencer.
// State encoding, job descriptor layout and descriptor validity check.
package search_pkg;

    localparam int ADDR_W = 8;
    localparam int ID_W   = 4;
    localparam int JOB_W  = 4 * ADDR_W + ID_W;

    localparam logic [ADDR_W-1:0] NOT_FOUND = 8'hFF;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_LOAD    = 6'b000010,
        S_CLEAR   = 6'b000100,
        S_RUN     = 6'b001000,
        S_CAPTURE = 6'b010000,
        S_EMIT    = 6'b100000
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] p;
        logic [ADDR_W-1:0] pl;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] bl;
        logic [ID_W-1:0]   id;
    } job_t;

    // Block must lie inside the 256-byte space, so the end is a 9-bit sum.
    function automatic logic job_ok(
        input logic [ADDR_W-1:0] pl,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] bl
    );
        return (pl != '0) && (pl <= bl) &&
               (({1'b0, b} + {1'b0, bl}) <= 9'd256);
    endfunction

endpackage

// File: rtl/search_sequencer_job_fifo.sv
// Job descriptor FIFO with async reset.
// Same-cycle push and pop are allowed; full/empty are exact.
module job_fifo
    import search_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  job_t wr_data,
    output job_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    job_t           mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign rd_data = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= wr_data;
    end

endmodule

// File: rtl/search_sequencer.sv
// Job driver for the pattern-search engine: queue, run, time out, report.
// Define SEARCH_SEQ_STATS_EN to add saturating job/hit/timeout counters.
module search_sequencer
    import search_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CLEAR_CYCLES   = 2
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_p,
    input  logic [ADDR_W-1:0] job_pl,
    input  logic [ADDR_W-1:0] job_b,
    input  logic [ADDR_W-1:0] job_bl,
    output logic [ADDR_W-1:0] srch_p,
    output logic [ADDR_W-1:0] srch_pl,
    output logic [ADDR_W-1:0] srch_b,
    output logic [ADDR_W-1:0] srch_bl,
    output logic              srch_reset,
    output logic              srch_activate,
    input  logic              srch_done,
    input  logic [ADDR_W-1:0] srch_found,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_found,
    output logic [ID_W-1:0]   res_id,
    output logic              res_timeout,
`ifdef SEARCH_SEQ_STATS_EN
    output logic              res_err,
    output logic [15:0]       stat_jobs,
    output logic [15:0]       stat_hits,
    output logic [7:0]        stat_timeouts
`else
    output logic              res_err
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t          state;
    job_t            wr_job;
    job_t            rd_job;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] id_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [CW-1:0]   clr_cnt;

    assign job_ready = !fifo_full && !reset;
    assign push      = job_valid && job_ready;
    assign pop       = (state == S_IDLE) && !fifo_empty && !res_valid;

    assign wr_job = '{p: job_p, pl: job_pl, b: job_b, bl: job_bl, id: id_cnt};

    job_fifo #(
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_job),
        .rd_data (rd_job),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            id_cnt <= '0;
        else if (push)
            id_cnt <= id_cnt + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            srch_p        <= '0;
            srch_pl       <= '0;
            srch_b        <= '0;
            srch_bl       <= '0;
            srch_reset    <= 1'b1;
            srch_activate <= 1'b0;
            res_valid     <= 1'b0;
            res_found     <= NOT_FOUND;
            res_id        <= '0;
            res_timeout   <= 1'b0;
            res_err       <= 1'b0;
            tmo_cnt       <= '0;
            clr_cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    srch_reset <= 1'b0;
                    if (pop) begin
                        srch_p      <= rd_job.p;
                        srch_pl     <= rd_job.pl;
                        srch_b      <= rd_job.b;
                        srch_bl     <= rd_job.bl;
                        res_id      <= rd_job.id;
                        res_found   <= NOT_FOUND;
                        res_err     <= 1'b0;
                        res_timeout <= 1'b0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (job_ok(srch_pl, srch_b, srch_bl)) begin
                        srch_reset <= 1'b1;
                        clr_cnt    <= '0;
                        state      <= S_CLEAR;
                    end else begin
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                        srch_reset    <= 1'b0;
                        srch_activate <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= S_RUN;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // done takes priority over an expiring timer
                    if (srch_done) begin
                        res_found     <= srch_found;
                        srch_activate <= 1'b0;
                        state         <= S_CAPTURE;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        res_timeout   <= 1'b1;
                        srch_activate <= 1'b0;
                        state         <= S_CAPTURE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    srch_activate <= 1'b0;
                    res_valid     <= 1'b1;
                    state         <= S_EMIT;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    srch_activate <= 1'b0;
                    res_valid     <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEARCH_SEQ_STATS_EN
    logic res_hs;
    assign res_hs = res_valid && res_ready;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            stat_jobs     <= '0;
            stat_hits     <= '0;
            stat_timeouts <= '0;
        end else if (res_hs) begin
            if (stat_jobs != '1)
                stat_jobs <= stat_jobs + 1'b1;
            if ((res_found != NOT_FOUND) && !res_err && !res_timeout &&
                (stat_hits != '1))
                stat_hits <= stat_hits + 1'b1;
            if (res_timeout && (stat_timeouts != '1))
                stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_search_sequencer.sv
// Scoreboard bench for search_sequencer with a behavioural engine model.
// Expected results are queued at job acceptance and checked by a monitor.
module tb_search_sequencer;
    import search_pkg::*;

    typedef struct {
        logic [7:0] found;
        logic [3:0] id;
        logic       err;
        logic       to;
    } exp_t;

    typedef struct {
        int         delay;
        logic [7:0] found;
        bit         hang;
    } eng_t;

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [7:0] job_p = '0;
    logic [7:0] job_pl = '0;
    logic [7:0] job_b = '0;
    logic [7:0] job_bl = '0;
    logic [7:0] srch_p;
    logic [7:0] srch_pl;
    logic [7:0] srch_b;
    logic [7:0] srch_bl;
    logic       srch_reset;
    logic       srch_activate;
    logic       srch_done = 1'b0;
    logic [7:0] srch_found = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_found;
    logic [3:0] res_id;
    logic       res_timeout;
    logic       res_err;
`ifdef SEARCH_SEQ_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_hits;
    logic [7:0]  stat_timeouts;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    eng_t eng_q[$];
    eng_t cur;
    int   run_cnt = 0;
    int   act_cnt = 0;
    int   act_starts = 0;
    int   rst_hi_cnt = 0;
    logic [3:0] tb_id = '0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    search_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64),
        .CLEAR_CYCLES   (2)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset         (reset),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_p         (job_p),
        .job_pl        (job_pl),
        .job_b         (job_b),
        .job_bl        (job_bl),
        .srch_p        (srch_p),
        .srch_pl       (srch_pl),
        .srch_b        (srch_b),
        .srch_bl       (srch_bl),
        .srch_reset    (srch_reset),
        .srch_activate (srch_activate),
        .srch_done     (srch_done),
        .srch_found    (srch_found),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_found     (res_found),
        .res_id        (res_id),
        .res_timeout   (res_timeout),
`ifdef SEARCH_SEQ_STATS_EN
        .res_err       (res_err),
        .stat_jobs     (stat_jobs),
        .stat_hits     (stat_hits),
        .stat_timeouts (stat_timeouts)
`else
        .res_err       (res_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: done with a programmed result after N active cycles.
    always @(negedge CLK100MHZ) begin
        if (reset || !srch_activate) begin
            run_cnt   = 0;
            srch_done = 1'b0;
        end else begin
            if (run_cnt == 0) begin
                act_starts++;
                if (eng_q.size() > 0)
                    cur = eng_q.pop_front();
                else
                    cur = '{delay: 0, found: 8'h00, hang: 1'b1};
            end
            run_cnt++;
            act_cnt++;
            srch_done  = !cur.hang && (run_cnt == cur.delay);
            srch_found = cur.found;
        end
        if (!reset && srch_reset)
            rst_hi_cnt++;
    end

    // Monitor: every result handshake pops one expectation.
    always @(negedge CLK100MHZ) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id %0d expected none",
                         res_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_found", 32'(res_found), 32'(e.found));
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_err", 32'(res_err), 32'(e.err));
                chk("res_timeout", 32'(res_timeout), 32'(e.to));
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK100MHZ);
        #1;
        reset = 1'b1;
        sb.delete();
        eng_q.delete();
        tb_id = '0;
        repeat (2) @(posedge CLK100MHZ);
        #1;
        chk("rst_srch_reset", 32'(srch_reset), 32'd1);
        chk("rst_job_ready", 32'(job_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_found", 32'(res_found), 32'hFF);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_activate", 32'(srch_activate), 32'd0);
        chk("rst_srch_p", 32'(srch_p), 32'd0);
        reset = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        chk("post_rst_srch_reset", 32'(srch_reset), 32'd0);
        chk("post_rst_job_ready", 32'(job_ready), 32'd1);
    endtask

    task automatic push_job(input logic [7:0] p, input logic [7:0] pl,
                            input logic [7:0] b, input logic [7:0] bl,
                            input logic err, input int dly,
                            input logic [7:0] efound, input bit hang);
        bit ok;
        exp_t e;
        ok = 1'b0;
        job_p = p;
        job_pl = pl;
        job_b = b;
        job_bl = bl;
        job_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge CLK100MHZ);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK100MHZ);
        #1;
        job_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got job_ready 0 expected 1");
        end else begin
            e.id    = tb_id;
            e.err   = err;
            e.to    = !err && hang;
            e.found = (err || hang) ? 8'hFF : efound;
            sb.push_back(e);
            if (!err)
                eng_q.push_back('{delay: dly, found: efound, hang: hang});
            tb_id = tb_id + 1'b1;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0)
                break;
            @(posedge CLK100MHZ);
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int s;
        do_reset();
        res_ready = 1'b1;

        // single valid job
        act_cnt = 0;
        rst_hi_cnt = 0;
        push_job(8'd0, 8'd3, 8'd10, 8'd20, 1'b0, 50, 8'd14, 1'b0);
        wait_drain(500);
        chk("clear_cycles", 32'(rst_hi_cnt), 32'd2);
        chk("run_cycles", 32'(act_cnt), 32'd50);

        // invalid descriptors
        act_cnt = 0;
        push_job(8'd0, 8'd0, 8'd10, 8'd20, 1'b1, 0, 8'h00, 1'b0);
        push_job(8'd0, 8'd5, 8'd10, 8'd3, 1'b1, 0, 8'h00, 1'b0);
        push_job(8'd0, 8'd2, 8'd250, 8'd10, 1'b1, 0, 8'h00, 1'b0);
        wait_drain(200);
        chk("invalid_no_activate", 32'(act_cnt), 32'd0);

        // timeout, then a normal job
        act_cnt = 0;
        push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 0, 8'h00, 1'b1);
        wait_drain(1000);
        chk("timeout_run_cycles", 32'(act_cnt), 32'd64);
        push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 5, 8'd7, 1'b0);
        wait_drain(500);

        // back-pressure
        do_reset();
        res_ready = 1'b0;
        s = act_starts;
        for (int i = 0; i < 5; i++)
            push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 3, 8'(20 + i), 1'b0);
        repeat (50) @(posedge CLK100MHZ);
        #1;
        chk("bp_job_ready", 32'(job_ready), 32'd0);
        chk("bp_one_exec", 32'(act_starts - s), 32'd1);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        fork
            begin
                repeat (3) @(posedge CLK100MHZ);
                #1;
                res_ready = 1'b1;
            end
            push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 3, 8'd25, 1'b0);
        join
        wait_drain(1000);

        // reset while job 2 runs
        do_reset();
        res_ready = 1'b1;
        s = act_starts;
        push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 3, 8'd40, 1'b0);
        push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 3, 8'd41, 1'b0);
        push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 0, 8'h00, 1'b1);
        for (int k = 0; k < 500; k++) begin
            if (act_starts >= s + 3)
                break;
            @(posedge CLK100MHZ);
        end
        chk("mid_job2_started", 32'(act_starts - s), 32'd3);
        repeat (5) @(posedge CLK100MHZ);
        #1;
        chk("mid_pending", 32'(sb.size()), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_activate", 32'(srch_activate), 32'd0);
        chk("mid_srch_reset", 32'(srch_reset), 32'd1);
        chk("mid_res_valid", 32'(res_valid), 32'd0);
        chk("mid_job_ready", 32'(job_ready), 32'd0);
        sb.delete();
        eng_q.delete();
        tb_id = '0;
        @(posedge CLK100MHZ);
        #1;
        reset = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        push_job(8'd1, 8'd2, 8'd4, 8'd8, 1'b0, 4, 8'd6, 1'b0);
        wait_drain(500);

        // id wrap over 17 jobs, 10 hits and 7 misses
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++)
            push_job(8'd0, 8'd2, 8'd0, 8'd8, 1'b0, 2,
                     (i < 10) ? 8'(30 + i) : 8'hFF, 1'b0);
        wait_drain(2000);
`ifdef SEARCH_SEQ_STATS_EN
        chk("stat_jobs", 32'(stat_jobs), 32'd17);
        chk("stat_hits", 32'(stat_hits), 32'd10);
        chk("stat_timeouts", 32'(stat_timeouts), 32'd0);
`endif

        repeat (5) @(posedge CLK100MHZ);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/search_sequencer.md
Name: search_sequencer

Overview:
- Upstream job driver for the pattern-search engine (`search`).
- Accepts search job descriptors over a valid/ready handshake and buffers them in a small FIFO.
- For each job it drives the engine's p/pl/b/bl/reset/activate inputs, waits for done or a timeout, and returns one tagged result per job over a second valid/ready handshake.
- Sits between the host-side command source (UART/switch decoder) and the `search` instance.

Parameters:
- FIFO_DEPTH, 4, job FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before the job is abandoned.
- CLEAR_CYCLES, 2, cycles srch_reset is held high before activate.

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  FIFO can accept (= !full).
- job_p  in  8  pattern start address.
- job_pl  in  8  pattern length.
- job_b  in  8  block start address.
- job_bl  in  8  block length.
- srch_p / srch_pl / srch_b / srch_bl  out  8 each  to the engine.
- srch_reset  out  1  engine restart.
- srch_activate  out  1  engine run enable.
- srch_done  in  1  engine done.
- srch_found  in  8  engine result (8'hFF = not found).
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_found  out  8  match address, or 8'hFF.
- res_id  out  4  job id, assigned at acceptance.
- res_timeout  out  1  job abandoned on timeout.
- res_err  out  1  descriptor rejected.

Behaviour:
- Reset state (async, active-high): FIFO empty, id counter 0, state IDLE, res_valid 0, res_found 8'hFF, res_id 0, res_timeout 0, res_err 0, srch_activate 0, srch_p/pl/b/bl 0.
- srch_reset is 1 while reset is asserted and drops to 0 on the first clock after release.
- job_ready is 0 during reset.
- Job acceptance:
  - A job is accepted on job_valid & job_ready.
  - {p, pl, b, bl, id} is written to the FIFO and the id counter increments (4-bit, wraps 15→0).
  - Push and pop in the same cycle are legal when the FIFO is non-empty; the count is unchanged.
  - On full, job_ready=0 and no push occurs.
- IDLE: if the FIFO is non-empty and res_valid=0, pop and go to LOAD.
- LOAD (1 cycle): latch the descriptor into srch_*.
  - Validity check: pl≠0, pl≤bl, and b+bl≤256 (9-bit sum).
  - Invalid → EMIT with res_err=1, res_found=8'hFF, no engine activity.
  - Valid → CLEAR.
- CLEAR: srch_reset=1 for CLEAR_CYCLES cycles, activate=0, then go to RUN.
- RUN:
  - srch_activate=1 and the timeout counter increments every cycle.
  - srch_done=1 → CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 without done → CAPTURE with res_timeout=1.
  - done and timeout in the same cycle: done wins, res_timeout=0.
- CAPTURE (1 cycle):
  - srch_activate=0.
  - res_found = srch_found on done; 8'hFF on timeout.
  - Go to EMIT.
- EMIT: res_valid=1 with stable res_* until res_ready; on the handshake cycle res_valid→0 and state→IDLE.
- Result latency: a valid job popped in IDLE at cycle t gives res_valid no earlier than t+1+CLEAR_CYCLES+(engine cycles)+2. An invalid job gives res_valid at t+2.
- Ordering and back-pressure:
  - Results return in acceptance order; exactly one result per accepted job.
  - The next job never starts while a result is unconsumed.
- srch_* are held stable from LOAD until the next LOAD.
- Reset mid-job: the job is dropped with no result, the FIFO is cleared, and the engine is held in reset.

Optional Feature:
- SEARCH_SEQ_STATS_EN defined adds outputs stat_jobs (16), stat_hits (16) and stat_timeouts (8), all saturating and reset to 0:
  - stat_jobs increments on each res handshake.
  - stat_hits increments when res_found≠8'hFF & !res_err & !res_timeout.
  - stat_timeouts increments on timeout results.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package search_pkg:
  - state encoding (IDLE, LOAD, CLEAR, RUN, CAPTURE, EMIT; one-hot);
  - NOT_FOUND = 8'hFF;
  - ADDR_W = 8, ID_W = 4;
  - job descriptor field widths (36-bit FIFO word).
- Sub-module job_fifo: synchronous FIFO, async reset, depth FIFO_DEPTH, full/empty flags, same-cycle push/pop.

Test Plan:
- Single job: p=0, pl=3, b=10, bl=20; engine model returns done with found=14 after 50 cycles.
  - Expect: srch_reset high 2 cycles; activate high until done; res_found=14, res_id=0, res_err=0, res_timeout=0.
- Invalid job: pl=0, then pl=5 with bl=3, then b=250 with bl=10.
  - Expect: each returns res_err=1, res_found=8'hFF, srch_activate never asserted.
- Timeout: TIMEOUT_CYCLES=64, engine never asserts done.
  - Expect: res_timeout=1, res_found=8'hFF at RUN cycle 64; the next job runs normally.
- Back-pressure: push 6 jobs with res_ready=0.
  - Expect: job_ready=0 after the FIFO fills; only 1 job executes.
  - Raise res_ready: ids 0..5 are returned in order, no loss or duplication.
- Reset mid-RUN: reset asserted during job id 2.
  - Expect: outputs go to reset values immediately, no result for id 2, and the next accepted job gets res_id=0.
- Id wrap: 17 jobs.
  - Expect: res_id sequence 0..15, 0.
  - With SEARCH_SEQ_STATS_EN and 10 hits, expect stat_jobs=17, stat_hits=10.
